// File: rtl/param_fifo.sv
// Parametrised single-clock circular-buffer FIFO with registered read, occupancy count and sticky error flags.
// Optional almost_full/almost_empty outputs are enabled by defining PARAM_FIFO_ALMOST_EN.
module param_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 7,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
`ifdef PARAM_FIFO_ALMOST_EN
  ,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
`ifdef PARAM_FIFO_ALMOST_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr_inc;
  logic [AW-1:0]     rd_ptr_inc;
  logic              rd_ok;
  logic              wr_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

`ifdef PARAM_FIFO_ALMOST_EN
  assign almost_full  = (count >= CW'(AFULL_TH));
  assign almost_empty = (count <= CW'(AEMPTY_TH));
`endif

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
  assign wr_ptr_inc = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
  assign rd_ptr_inc = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr_inc;
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr_inc;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        count <= count - CW'(1);
      end
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow  <= (overflow  & ~clr_err) | (wr_en & ~wr_ok);
      underflow <= (underflow & ~clr_err) | (rd_en & ~rd_ok);
    end
  end

endmodule
